// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target and master.
//   - i2c_state_e : target protocol state encoding
//   - I2C_ADDR_W / I2C_BYTE_W : address and data widths
//   - RW_READ / RW_WRITE : meaning of the R/W bit
//   - shift_in_msb() : MSB-first shift helper used by the bit receiver
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX_BYTE  = 3'd3,
        RX_ACK   = 3'd4,
        TX_BYTE  = 3'd5,
        TX_ACK   = 3'd6
    } i2c_state_e;

    // Append one received bit below the bits already collected (MSB first).
    function automatic logic [I2C_BYTE_W-1:0] shift_in_msb(
        input logic [I2C_BYTE_W-1:0] cur,
        input logic                  bit_in
    );
        return {cur[I2C_BYTE_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: conditions one bus line for sampling by the system clock.
//   2-FF synchronizer -> optional glitch filter -> 1-FF delay for edge detect.
//   Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN (filter needs FILTER_LEN
//   consecutive identical samples before the conditioned level changes).
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   line       : raw bus line
//   level      : conditioned line level
//   rise, fall : one-clk edge strobes of the conditioned level
module i2c_line_cond #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic dly_r;
    logic cond_s;

    if (FILTER_LEN < 1) begin : g_filter_len_check
        $error("i2c_line_cond: FILTER_LEN must be at least 1");
    end

    // Two-stage synchronizer; resets to the idle-high bus level to avoid a false edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= line;
            sync2_r <= sync1_r;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] run_cnt_r;
    logic             filt_r;

    // Glitch filter: count consecutive samples that differ from the filtered value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt_r <= '0;
            filt_r    <= 1'b1;
        end else if (sync2_r == filt_r) begin
            run_cnt_r <= '0;
        end else if (run_cnt_r == CNT_W'(FILTER_LEN - 1)) begin
            filt_r    <= sync2_r;
            run_cnt_r <= '0;
        end else begin
            run_cnt_r <= run_cnt_r + CNT_W'(1);
        end
    end

    assign cond_s = filt_r;
`else
    assign cond_s = sync2_r;
`endif

    // One-clk delay of the conditioned level for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly_r <= 1'b1;
        end else begin
            dly_r <= cond_s;
        end
    end

    assign level = cond_s;
    assign rise  = cond_s & ~dly_r;
    assign fall  = ~cond_s & dly_r;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with fixed 7-bit address, byte receive and transmit.
//   Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN (glitch filter on scl/sda).
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   scl        : bus clock from the master (never stretched)
//   sda        : open-drain data, driven 1'b0 or released (z)
//   rx_data    : last byte received in a write transfer
//   rx_valid   : one-clk pulse when rx_data updates
//   tx_data    : byte to send; sampled on the scl fall after tx_req
//   tx_req     : one-clk request for the next read byte
//   addressed  : high from address ACK until STOP / repeated START
//   rw         : R/W bit of the current transfer (1 = read)
//   busy       : high between START and STOP
//   stop_det   : one-clk pulse on STOP
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h55,
    parameter int unsigned           FILTER_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  addressed,
    output logic                  rw,
    output logic                  busy,
    output logic                  stop_det
);

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [I2C_BYTE_W-1:0] byte_in_s;

    i2c_state_e            state_r,     state_nx_s;
    logic [3:0]            bit_cnt_r,   bit_cnt_nx_s;
    logic [I2C_BYTE_W-1:0] shift_r,     shift_nx_s;
    logic [I2C_BYTE_W-1:0] rx_data_r,   rx_data_nx_s;
    logic                  sda_low_r,   sda_low_nx_s;
    logic                  ack_ok_r,    ack_ok_nx_s;
    logic                  rx_valid_r,  rx_valid_nx_s;
    logic                  tx_req_r,    tx_req_nx_s;
    logic                  addressed_r, addressed_nx_s;
    logic                  rw_r,        rw_nx_s;
    logic                  busy_r,      busy_nx_s;
    logic                  stop_det_r,  stop_det_nx_s;

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl_cond (
        .clk(clk), .rst_n(rst_n), .line(scl),
        .level(scl_lvl_s), .rise(scl_rise_s), .fall(scl_fall_s)
    );

    i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda_cond (
        .clk(clk), .rst_n(rst_n), .line(sda),
        .level(sda_lvl_s), .rise(sda_rise_s), .fall(sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_lvl_s;
    assign stop_s    = sda_rise_s & scl_lvl_s;
    assign byte_in_s = shift_in_msb(shift_r, sda_lvl_s);

    // Next-state and next-output logic; START/STOP override every state.
    // In the ACK states sda_low_r tells the drive phase from the release phase.
    always_comb begin
        state_nx_s     = state_r;
        bit_cnt_nx_s   = bit_cnt_r;
        shift_nx_s     = shift_r;
        rx_data_nx_s   = rx_data_r;
        sda_low_nx_s   = sda_low_r;
        ack_ok_nx_s    = ack_ok_r;
        addressed_nx_s = addressed_r;
        rw_nx_s        = rw_r;
        busy_nx_s      = busy_r;
        rx_valid_nx_s  = 1'b0;
        tx_req_nx_s    = 1'b0;
        stop_det_nx_s  = 1'b0;

        if (start_s) begin
            state_nx_s     = ADDR;
            bit_cnt_nx_s   = 4'd0;
            sda_low_nx_s   = 1'b0;
            ack_ok_nx_s    = 1'b0;
            addressed_nx_s = 1'b0;
            busy_nx_s      = 1'b1;
        end else if (stop_s) begin
            state_nx_s     = IDLE;
            sda_low_nx_s   = 1'b0;
            ack_ok_nx_s    = 1'b0;
            addressed_nx_s = 1'b0;
            busy_nx_s      = 1'b0;
            stop_det_nx_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nx_s = IDLE;
                end
                ADDR, RX_BYTE: begin
                    if (scl_rise_s) begin
                        shift_nx_s = byte_in_s;
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_nx_s = 4'd0;
                            if (state_r == RX_BYTE) begin
                                rx_data_nx_s  = byte_in_s;
                                rx_valid_nx_s = 1'b1;
                                state_nx_s    = RX_ACK;
                            end else if (byte_in_s[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
                                rw_nx_s    = byte_in_s[0];
                                state_nx_s = ADDR_ACK;
                            end else begin
                                state_nx_s = IDLE;
                            end
                        end else begin
                            bit_cnt_nx_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s && !sda_low_r) begin
                        sda_low_nx_s   = 1'b1;
                        addressed_nx_s = 1'b1;
                        tx_req_nx_s    = (rw_r == RW_READ);
                    end else if (scl_fall_s && (rw_r == RW_READ)) begin
                        shift_nx_s   = tx_data;
                        sda_low_nx_s = ~tx_data[I2C_BYTE_W-1];
                        bit_cnt_nx_s = 4'd0;
                        state_nx_s   = TX_BYTE;
                    end else if (scl_fall_s) begin
                        sda_low_nx_s = 1'b0;
                        bit_cnt_nx_s = 4'd0;
                        state_nx_s   = RX_BYTE;
                    end else begin
                        state_nx_s = ADDR_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall_s && !sda_low_r) begin
                        sda_low_nx_s = 1'b1;
                    end else if (scl_fall_s) begin
                        sda_low_nx_s = 1'b0;
                        state_nx_s   = RX_BYTE;
                    end else begin
                        state_nx_s = RX_ACK;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall_s && (bit_cnt_r == 4'd7)) begin
                        sda_low_nx_s = 1'b0;
                        bit_cnt_nx_s = 4'd0;
                        ack_ok_nx_s  = 1'b0;
                        state_nx_s   = TX_ACK;
                    end else if (scl_fall_s) begin
                        shift_nx_s   = {shift_r[I2C_BYTE_W-2:0], 1'b0};
                        sda_low_nx_s = ~shift_r[I2C_BYTE_W-2];
                        bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    end else begin
                        state_nx_s = TX_BYTE;
                    end
                end
                TX_ACK: begin
                    if (scl_rise_s && !sda_lvl_s) begin
                        tx_req_nx_s = 1'b1;
                        ack_ok_nx_s = 1'b1;
                    end else if (scl_rise_s) begin
                        state_nx_s = IDLE;
                    end else if (scl_fall_s && ack_ok_r) begin
                        shift_nx_s   = tx_data;
                        sda_low_nx_s = ~tx_data[I2C_BYTE_W-1];
                        bit_cnt_nx_s = 4'd0;
                        ack_ok_nx_s  = 1'b0;
                        state_nx_s   = TX_BYTE;
                    end else begin
                        state_nx_s = TX_ACK;
                    end
                end
                default: begin
                    state_nx_s   = IDLE;
                    sda_low_nx_s = 1'b0;
                end
            endcase
        end
    end

    // Protocol state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            sda_low_r   <= 1'b0;
            ack_ok_r    <= 1'b0;
            rx_valid_r  <= 1'b0;
            tx_req_r    <= 1'b0;
            addressed_r <= 1'b0;
            rw_r        <= RW_WRITE;
            busy_r      <= 1'b0;
            stop_det_r  <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            bit_cnt_r   <= bit_cnt_nx_s;
            shift_r     <= shift_nx_s;
            rx_data_r   <= rx_data_nx_s;
            sda_low_r   <= sda_low_nx_s;
            ack_ok_r    <= ack_ok_nx_s;
            rx_valid_r  <= rx_valid_nx_s;
            tx_req_r    <= tx_req_nx_s;
            addressed_r <= addressed_nx_s;
            rw_r        <= rw_nx_s;
            busy_r      <= busy_nx_s;
            stop_det_r  <= stop_det_nx_s;
        end
    end

    assign sda       = sda_low_r ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign tx_req    = tx_req_r;
    assign addressed = addressed_r;
    assign rw        = rw_r;
    assign busy      = busy_r;
    assign stop_det  = stop_det_r;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: self-checking bench for i2c_slave. A behavioural master drives
// scl and pulls sda low (bus pulled up); a write-transfer table is applied in a
// loop, followed by hand-written read, repeated-START, reset and glitch cases.
module tb_i2c_slave;

    localparam int Q = 8;   // clk cycles per quarter of an I2C bit

    logic       clk;
    logic       rst_n;
    logic       scl_drv;
    logic       sda_pull_low;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, addressed, rw, busy, stop_det;
    wire        sda_w;

    assign sda_w = sda_pull_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave dut (
        .clk(clk), .rst_n(rst_n), .scl(scl_drv), .sda(sda_w),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_req(tx_req), .addressed(addressed), .rw(rw),
        .busy(busy), .stop_det(stop_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Event counters sampled away from the active edge
    int rx_cnt = 0, tx_req_cnt = 0, stop_cnt = 0, addr_cyc = 0, busy_cyc = 0;
    always @(negedge clk) begin
        rx_cnt     <= rx_cnt + (rx_valid ? 1 : 0);
        tx_req_cnt <= tx_req_cnt + (tx_req ? 1 : 0);
        stop_cnt   <= stop_cnt + (stop_det ? 1 : 0);
        addr_cyc   <= addr_cyc + (addressed ? 1 : 0);
        busy_cyc   <= busy_cyc + (busy ? 1 : 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_pull_low = 1'b0; wait_clks(Q);
        scl_drv = 1'b1;      wait_clks(Q);
        sda_pull_low = 1'b1; wait_clks(Q);
        scl_drv = 1'b0;      wait_clks(Q);
    endtask

    task automatic bus_stop();
        sda_pull_low = 1'b1; wait_clks(Q);
        scl_drv = 1'b1;      wait_clks(Q);
        sda_pull_low = 1'b0; wait_clks(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_pull_low = ~b; wait_clks(Q);
        scl_drv = 1'b1;    wait_clks(2 * Q);
        scl_drv = 1'b0;    wait_clks(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_pull_low = 1'b0; wait_clks(Q);
        scl_drv = 1'b1;      wait_clks(Q);
        b = sda_w;           wait_clks(Q);
        scl_drv = 1'b0;      wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bv);
            b[i] = bv;
        end
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data;
        logic       exp_addr_ack;   // bus level on 9th clock: 0 = ACK
        logic [7:0] exp_rx_data;
        int         exp_rx_pulses;
        logic       exp_rw;
    } wr_vec_t;

    wr_vec_t vecs [5];

    initial begin
        logic       ack_a, ack_d, bv;
        logic [7:0] byte_v;
        int         rx0, tx0, st0, ad0, bz0;

        vecs[0] = '{8'hAA, 8'h3C, 1'b0, 8'h3C, 1, 1'b0};   // 0x55/W
        vecs[1] = '{8'h54, 8'hFF, 1'b1, 8'h3C, 0, 1'b0};   // 0x2A/W, ignored
        vecs[2] = '{8'hAA, 8'h00, 1'b0, 8'h00, 1, 1'b0};
        vecs[3] = '{8'hAC, 8'h77, 1'b1, 8'h00, 0, 1'b0};   // 0x56/W, ignored
        vecs[4] = '{8'hAA, 8'hFF, 1'b0, 8'hFF, 1, 1'b0};

        rst_n = 1'b0; scl_drv = 1'b1; sda_pull_low = 1'b0; tx_data = 8'h00;
        wait_clks(4);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_addressed", {31'd0, addressed}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stop_det", {31'd0, stop_det}, 32'd0);
        check("rst_sda_released", {31'd0, sda_w}, 32'd1);
        rst_n = 1'b1;
        wait_clks(2 * Q);

        // Table of write transfers
        for (int v = 0; v < 5; v++) begin
            rx0 = rx_cnt; st0 = stop_cnt; ad0 = addr_cyc;
            bus_start();
            check($sformatf("v%0d_busy_after_start", v), {31'd0, busy}, 32'd1);
            send_byte(vecs[v].addr_byte, ack_a);
            check($sformatf("v%0d_addr_ack", v), {31'd0, ack_a}, {31'd0, vecs[v].exp_addr_ack});
            if (ack_a == 1'b0) begin
                send_byte(vecs[v].data, ack_d);
                check($sformatf("v%0d_data_ack", v), {31'd0, ack_d}, 32'd0);
            end
            bus_stop();
            check($sformatf("v%0d_rx_pulses", v), rx_cnt - rx0, vecs[v].exp_rx_pulses);
            check($sformatf("v%0d_rx_data", v), {24'd0, rx_data}, {24'd0, vecs[v].exp_rx_data});
            check($sformatf("v%0d_rw", v), {31'd0, rw}, {31'd0, vecs[v].exp_rw});
            check($sformatf("v%0d_addressed_seen", v), {31'd0, addr_cyc != ad0},
                  {31'd0, ~vecs[v].exp_addr_ack});
            check($sformatf("v%0d_stop_pulses", v), stop_cnt - st0, 32'd1);
            check($sformatf("v%0d_busy_idle", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_addressed_end", v), {31'd0, addressed}, 32'd0);
        end

        // Read: A5 with master ACK, then 5A with master NACK
        tx0 = tx_req_cnt; st0 = stop_cnt;
        tx_data = 8'hA5;
        bus_start();
        send_byte(8'hAB, ack_a);
        check("rd_addr_ack", {31'd0, ack_a}, 32'd0);
        check("rd_rw", {31'd0, rw}, 32'd1);
        read_byte(byte_v);
        check("rd_byte0", {24'd0, byte_v}, 32'hA5);
        tx_data = 8'h5A;
        send_bit(1'b0);
        read_byte(byte_v);
        check("rd_byte1", {24'd0, byte_v}, 32'h5A);
        send_bit(1'b1);
        wait_clks(Q);
        check("rd_sda_released_after_nack", {31'd0, sda_w}, 32'd1);
        check("rd_tx_req_pulses", tx_req_cnt - tx0, 32'd2);
        bus_stop();
        check("rd_stop_pulses", stop_cnt - st0, 32'd1);

        // Write 0x11 then repeated START into a read of C3
        st0 = stop_cnt;
        tx_data = 8'hC3;
        bus_start();
        send_byte(8'hAA, ack_a);
        send_byte(8'h11, ack_d);
        check("rs_wr_acks", {30'd0, ack_a, ack_d}, 32'd0);
        check("rs_rx_data", {24'd0, rx_data}, 32'h11);
        check("rs_rw_write", {31'd0, rw}, 32'd0);
        bus_start();
        send_byte(8'hAB, ack_a);
        check("rs_rd_addr_ack", {31'd0, ack_a}, 32'd0);
        check("rs_rw_read", {31'd0, rw}, 32'd1);
        read_byte(byte_v);
        check("rs_rd_byte", {24'd0, byte_v}, 32'hC3);
        check("rs_no_stop_between", stop_cnt - st0, 32'd0);
        send_bit(1'b1);
        bus_stop();

        // Reset in the middle of a transmitted byte
        tx_data = 8'h00;
        bus_start();
        send_byte(8'hAB, ack_a);
        for (int i = 0; i < 3; i++) read_bit(bv);
        check("mid_tx_sda_driven", {31'd0, sda_w}, 32'd0);
        rst_n = 1'b0;
        wait_clks(1);
        check("mid_rst_sda", {31'd0, sda_w}, 32'd1);
        check("mid_rst_outputs", {24'd0, rx_data, rx_valid, tx_req, addressed, rw, busy, stop_det, 2'b00},
              32'd0);
        rst_n = 1'b1;
        scl_drv = 1'b1;
        wait_clks(2 * Q);
        bus_start();
        send_byte(8'hAA, ack_a);
        send_byte(8'h77, ack_d);
        bus_stop();
        check("post_rst_acks", {30'd0, ack_a, ack_d}, 32'd0);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'h77);

        // One-clk low glitch on sda while scl is high
        bz0 = busy_cyc;
        @(negedge clk) sda_pull_low = 1'b1;
        @(negedge clk) sda_pull_low = 1'b0;
        wait_clks(4 * Q);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("glitch_start_seen", {31'd0, busy_cyc != bz0}, 32'd0);
`else
        check("glitch_start_seen", {31'd0, busy_cyc != bz0}, 32'd1);
`endif
        bus_start();
        bus_stop();
        check("glitch_final_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) that answers the existing i2c_master on the same two-wire bus.
- Samples scl and sda with the system clock (no clock-domain crossing beyond a 2-FF synchronizer).
- Detects START/STOP, matches a fixed 7-bit address and ACKs it.
- Write transfers: receives bytes and hands them to user logic. Read transfers: shifts out user-supplied bytes.
- Used as the on-chip bus model in master benches and as a real peripheral front-end.

Parameters:
- SLAVE_ADDR, 7'h55, 7-bit address this target responds to.
- FILTER_LEN, 3, number of consecutive equal samples required by the glitch filter (only used with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- scl  in  1  bus clock from the master (target never stretches).
- sda  inout  1  open-drain data; driven 1'b0 or 1'bz only, never 1'b1.
- rx_data  out  8  last byte received in a write transfer.
- rx_valid  out  1  one-clk pulse when rx_data is updated.
- tx_data  in  8  byte to transmit in a read transfer.
- tx_req  out  1  one-clk pulse requesting tx_data for the next read byte.
- addressed  out  1  high from address ACK until STOP or repeated START.
- rw  out  1  R/W bit of the current transfer (1 = read).
- busy  out  1  high between START and STOP.
- stop_det  out  1  one-clk pulse on STOP.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, sda released (z), rx_data=0, rx_valid=0, tx_req=0, addressed=0, rw=0, busy=0, stop_det=0, bit counter=0.
- Input path: scl/sda go through a 2-FF synchronizer, then a 1-FF delay for edge detection. Event detection latency is 3 clk after the pin change.
  - scl_rise / scl_fall: edges of the synchronized scl.
  - START: sda falls while synchronized scl = 1.
  - STOP: sda rises while synchronized scl = 1.
- START and STOP take priority over every state and are checked before the bit logic.
  - START (including repeated START): go to ADDR, bit counter=0, release sda, addressed=0, busy=1.
  - STOP: go to IDLE, release sda, addressed=0, busy=0, stop_det pulses once.
- Bits are sampled on scl_rise. sda drive changes only on scl_fall, so data is never changed while scl is high.
- ADDR: shift in 8 bits, MSB first.
  - After the 8th scl_rise: compare bits[7:1] with SLAVE_ADDR.
  - Match: rw=bit0, go to ADDR_ACK.
  - Mismatch: go to IDLE (sda untouched until the next START).
- ADDR_ACK:
  - At the next scl_fall, drive sda=0 and set addressed=1.
  - If rw=1, pulse tx_req in that same clk.
  - At the scl_fall after the ACK clock: rw=0 → release sda, go to RX_BYTE; rw=1 → load shift register from tx_data, drive bit 7, go to TX_BYTE.
- RX_BYTE:
  - Shift 8 bits.
  - On the 8th scl_rise: rx_data ← byte and rx_valid pulses (same clk), go to RX_ACK.
- RX_ACK: drive 0 at the next scl_fall; at the following scl_fall release sda and return to RX_BYTE. Every byte is ACKed.
- TX_BYTE:
  - Bit value 0 drives sda low; bit value 1 releases sda.
  - At each scl_fall, present the next bit.
  - At the scl_fall after the 8th bit: release sda, go to TX_ACK.
- TX_ACK: sample the master's ACK on scl_rise.
  - ACK (0): pulse tx_req. At the next scl_fall load tx_data, drive bit 7, go to TX_BYTE.
  - NACK (1): go to IDLE with sda released; wait for STOP or START.
- tx_data must be stable from the tx_req pulse until the next scl_fall. It is latched only on that scl_fall.
- Bit counter is 4 bits and wraps to 0 at each byte boundary; there is no byte limit.
- rw and rx_data hold their values after STOP until overwritten.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: after the synchronizer, each line only changes its filtered value after FILTER_LEN consecutive identical samples. Pulses shorter than FILTER_LEN clk are rejected. Adds FILTER_LEN clk of latency to all events.
- Undefined: synchronizer outputs are used directly. No filter registers are synthesized.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK);
  - I2C_ADDR_W=7 and I2C_BYTE_W=8;
  - RW_READ=1 and RW_WRITE=0.
- i2c_master is updated to use the same package.
- One sub-module: i2c_line_cond. It is instantiated twice (scl, sda) and contains the synchronizer, the optional glitch filter and the rise/fall detector.

Test Plan:
- Write 0x55/W then 0x3C, STOP → target ACKs both bytes (sda=0 on 9th clocks); rx_valid pulses once with rx_data=0x3C; rw=0; stop_det pulses.
- Address 0x2A/W → no ACK (sda stays z); addressed=0; rx_valid never pulses; bus returns to IDLE after STOP.
- Read 0x55/R with tx_data=0xA5, master ACK then tx_data=0x5A, master NACK, STOP → sda carries A5 then 5A MSB-first; tx_req pulses twice; sda released after NACK.
- Write 0x55/W with data 0x11, then repeated START 0x55/R with tx_data=0xC3 → rx_data=0x11; rw toggles to 1; byte C3 is shifted out without STOP in between.
- rst_n asserted mid-byte during TX_BYTE → next clk: sda=z, all outputs at reset values; next full transaction completes normally.
- With I2C_SLAVE_GLITCH_FILTER_EN: a 1-clk low glitch on sda while scl is high → no START/STOP detected, state unchanged. Without the macro, the same glitch is detected as START and the state goes to ADDR.
